// File: rtl/mc_ctrl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mc_ctrl_seq                                                  |
// | Description : Multi-cycle control sequencer for the MIPS-subset datapath.  |
// |               Drives the PC/IR/ALUout/regfile/memory enables from the      |
// |               current state and opcode. Memory accesses wait on mem_ack    |
// |               and are bounded by a timeout. Undefined opcodes and missing  |
// |               acks trap. stall_in freezes the sequencer. Free-running      |
// |               cycle and retired-instruction counters are included.         |
// | Option      : MC_STALL_STATS_EN - when defined, stall_cnt counts stalled   |
// |               cycles outside TRAP; otherwise stall_cnt is tied to 0.       |
// | Ports       : multi_clk, rst_out (async, active-high)                      |
// |               opcode[5:0], stall_in, mem_ack                 - inputs      |
// |               state[3:0]                                     - state code  |
// |               pc_write .. alu_src_a, pc_source/alu_op/alu_src_b - controls |
// |               illegal_op, mem_timeout                        - sticky flags|
// |               cycle_cnt, instr_cnt, stall_cnt [CNT_W-1:0]    - counters    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mc_ctrl_seq #(
  parameter int CNT_W       = 16,
  parameter int TO_W        = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             multi_clk,
  input  logic             rst_out,
  input  logic [5:0]       opcode,
  input  logic             stall_in,
  input  logic             mem_ack,
  output logic [3:0]       state,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             ext_zero,
  output logic             alu_out_write,
  output logic             alu_src_a,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_op,
  output logic [1:0]       alu_src_b,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [3:0] {
    ST_IF    = 4'd0,
    ST_ID    = 4'd1,
    ST_MADDR = 4'd2,
    ST_MRD   = 4'd3,
    ST_MWB   = 4'd4,
    ST_MWR   = 4'd5,
    ST_REX   = 4'd6,
    ST_RWB   = 4'd7,
    ST_BR    = 4'd8,
    ST_JMP   = 4'd9,
    ST_IEX   = 4'd10,
    ST_IWB   = 4'd11,
    ST_TRAP  = 4'd12,
    ST_RSV13 = 4'd13,
    ST_RSV14 = 4'd14,
    ST_RSV15 = 4'd15
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LUI   = 6'b001111;

  // The wait counter holds the number of ack-less cycles already spent, so the
  // cycle that would make it reach MEM_TIMEOUT is the one that traps.
  localparam logic [TO_W-1:0] c_TO_LIMIT = TO_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_illegal;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instr_cnt;

  logic             w_ack;
  logic             w_wait_state;
  logic             w_to_hit;
  logic             w_set_illegal;
  logic             w_retire;

  // mem_ack only counts while the sequencer is running.
  assign w_ack        = mem_ack & ~stall_in;
  assign w_wait_state = (r_state == ST_IF) || (r_state == ST_MRD) || (r_state == ST_MWR);
  assign w_to_hit     = w_wait_state & ~stall_in & ~mem_ack & (r_to_cnt == c_TO_LIMIT);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    w_retire      = 1'b0;
    if (!stall_in) begin
      case (r_state)
        ST_IF: begin
          if (mem_ack)       w_next = ST_ID;
          else if (w_to_hit) w_next = ST_TRAP;
        end
        ST_ID: begin
          case (opcode)
            c_OP_RTYPE:                                 w_next = ST_REX;
            c_OP_LW, c_OP_SW:                           w_next = ST_MADDR;
            c_OP_BEQ, c_OP_BNE:                         w_next = ST_BR;
            c_OP_J:                                     w_next = ST_JMP;
            c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_LUI:   w_next = ST_IEX;
            default: begin
              w_next        = ST_TRAP;
              w_set_illegal = 1'b1;
            end
          endcase
        end
        ST_MADDR: w_next = (opcode == c_OP_SW) ? ST_MWR : ST_MRD;
        ST_MRD: begin
          if (mem_ack)       w_next = ST_MWB;
          else if (w_to_hit) w_next = ST_TRAP;
        end
        ST_MWR: begin
          if (mem_ack) begin
            w_next   = ST_IF;
            w_retire = 1'b1;
          end else if (w_to_hit) begin
            w_next = ST_TRAP;
          end
        end
        ST_REX: w_next = ST_RWB;
        ST_IEX: w_next = ST_IWB;
        ST_MWB, ST_RWB, ST_BR, ST_JMP, ST_IWB: begin
          w_next   = ST_IF;
          w_retire = 1'b1;
        end
        ST_TRAP: w_next = ST_TRAP;
        default: begin
          // Reserved encodings are never entered normally; treat as corruption.
          w_next        = ST_TRAP;
          w_set_illegal = 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State, timeout, flags and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge multi_clk or posedge rst_out) begin
    if (rst_out) begin
      r_state     <= ST_IF;
      r_to_cnt    <= '0;
      r_illegal   <= 1'b0;
      r_timeout   <= 1'b0;
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      r_state     <= w_next;
      if (!stall_in) begin
        // Count only while sitting in the same wait state; any exit clears.
        if (w_wait_state && !mem_ack && (w_next == r_state))
          r_to_cnt <= r_to_cnt + TO_W'(1);
        else
          r_to_cnt <= '0;
      end
      if (w_set_illegal) r_illegal   <= 1'b1;
      if (w_to_hit)      r_timeout   <= 1'b1;
      if (w_retire)      r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Datapath controls
  // --------------------------------------------------------------------------
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    ext_zero      = 1'b0;
    alu_out_write = 1'b0;
    alu_src_a     = 1'b0;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    alu_src_b     = 2'b00;
    case (r_state)
      ST_IF: begin
        mem_read = 1'b1;
        // Fetch completes this cycle: latch IR and compute PC+4.
        if (w_ack) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
        end
      end
      ST_ID: begin
        alu_src_b     = 2'b11;
        alu_out_write = 1'b1;
      end
      ST_MADDR: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b10;
        alu_out_write = 1'b1;
      end
      ST_MRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      ST_REX: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b10;
        alu_out_write = 1'b1;
      end
      ST_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BR: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (opcode == c_OP_BNE);
      end
      ST_JMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      ST_IEX: begin
        alu_src_a     = 1'b1;
        alu_src_b     = (opcode == c_OP_LUI) ? 2'b11 : 2'b10;
        ext_zero      = (opcode == c_OP_ANDI) || (opcode == c_OP_ORI);
        alu_op        = (opcode == c_OP_ADDI) ? 2'b00 : 2'b11;
        alu_out_write = 1'b1;
      end
      ST_IWB: begin
        reg_write = 1'b1;
      end
      default: ;
    endcase

    // A stall suppresses every write strobe; reads and selects keep their values.
    if (stall_in) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      alu_out_write = 1'b0;
    end

    // Reset abandons any bus access immediately, without waiting for a clock.
    if (rst_out) begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      alu_out_write = 1'b0;
    end
  end

  assign state       = r_state;
  assign illegal_op  = r_illegal;
  assign mem_timeout = r_timeout;
  assign cycle_cnt   = r_cycle_cnt;
  assign instr_cnt   = r_instr_cnt;

`ifdef MC_STALL_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge multi_clk or posedge rst_out) begin
    if (rst_out)
      r_stall_cnt <= '0;
    else if (stall_in && (r_state != ST_TRAP))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mc_ctrl_seq                                               |
// | Description : Self-checking bench for mc_ctrl_seq. A driver applies        |
// |               directed and random stimulus, pushing the expected response  |
// |               of each cycle into a queue; a monitor pops and compares.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mc_ctrl_seq;

  localparam int CNT_W       = 16;
  localparam int TO_W        = 4;
  localparam int MEM_TIMEOUT = 15;

  localparam int S_IF = 0, S_ID = 1, S_MADDR = 2, S_MRD = 3, S_MWB = 4, S_MWR = 5;
  localparam int S_REX = 6, S_RWB = 7, S_BR = 8, S_JMP = 9, S_IEX = 10, S_IWB = 11;
  localparam int S_TRAP = 12;

  logic             multi_clk = 1'b0;
  logic             rst_out   = 1'b1;
  logic [5:0]       opcode    = 6'd0;
  logic             stall_in  = 1'b0;
  logic             mem_ack   = 1'b0;
  logic [3:0]       state;
  logic             pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
  logic             ir_write, mem_to_reg, reg_write, reg_dst, ext_zero;
  logic             alu_out_write, alu_src_a;
  logic [1:0]       pc_source, alu_op, alu_src_b;
  logic             illegal_op, mem_timeout;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt, stall_cnt;

  always #5 multi_clk = ~multi_clk;

  mc_ctrl_seq #(.CNT_W(CNT_W), .TO_W(TO_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .multi_clk(multi_clk), .rst_out(rst_out), .opcode(opcode),
    .stall_in(stall_in), .mem_ack(mem_ack), .state(state),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
    .ext_zero(ext_zero), .alu_out_write(alu_out_write), .alu_src_a(alu_src_a),
    .pc_source(pc_source), .alu_op(alu_op), .alu_src_b(alu_src_b),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
  );

  logic [18:0] dut_ctl;
  assign dut_ctl = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
                    ir_write, mem_to_reg, reg_write, reg_dst, ext_zero, alu_out_write,
                    alu_src_a, pc_source, alu_op, alu_src_b};

  typedef struct packed {
    logic [3:0]       st;
    logic [18:0]      ctl;
    logic             ill;
    logic             tmo;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] ins;
    logic [CNT_W-1:0] stl;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: current state, remaining per-instruction route, counters.
  int               m_st;
  int               m_path[$];
  int               m_wait;
  logic             m_ill, m_tmo;
  logic [CNT_W-1:0] m_cyc, m_ins, m_stl;

  logic [5:0] ops [12] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                           6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001111,
                           6'b111111, 6'b000011};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected controls for one cycle, written from the per-state control list.
  function automatic logic [18:0] exp_ctl(input int st, input logic [5:0] op,
                                          input logic s, input logic a);
    logic pw = 0, pwc = 0, bne = 0, io = 0, mr = 0, mw = 0, irw = 0, m2r = 0;
    logic rw = 0, rd = 0, ez = 0, aow = 0, asa = 0;
    logic [1:0] ps = 0, aop = 0, asb = 0;
    case (st)
      S_IF:    begin mr = 1; if (a && !s) begin irw = 1; pw = 1; asb = 2'b01; end end
      S_ID:    begin asb = 2'b11; aow = 1; end
      S_MADDR: begin asa = 1; asb = 2'b10; aow = 1; end
      S_MRD:   begin mr = 1; io = 1; end
      S_MWB:   begin rw = 1; m2r = 1; end
      S_MWR:   begin mw = 1; io = 1; end
      S_REX:   begin asa = 1; aop = 2'b10; aow = 1; end
      S_RWB:   begin rw = 1; rd = 1; end
      S_BR:    begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; bne = (op == 6'b000101); end
      S_JMP:   begin pw = 1; ps = 2'b10; end
      S_IEX: begin
        asa = 1; aow = 1;
        asb = (op == 6'b001111) ? 2'b11 : 2'b10;
        ez  = (op == 6'b001100) || (op == 6'b001101);
        aop = (op == 6'b001000) ? 2'b00 : 2'b11;
      end
      S_IWB:   rw = 1;
      default: ;
    endcase
    if (s) begin pw = 0; pwc = 0; irw = 0; rw = 0; mw = 0; aow = 0; end
    return {pw, pwc, bne, io, mr, mw, irw, m2r, rw, rd, ez, aow, asa, ps, aop, asb};
  endfunction

  // Advance the model by one clock: instructions walk a route of states after
  // decode; the three memory-wait states hold until an ack or the timeout.
  task automatic advance(input logic s, input logic a);
    m_cyc++;
`ifdef MC_STALL_STATS_EN
    if (s && m_st != S_TRAP) m_stl++;
`endif
    if (s || m_st == S_TRAP) return;
    if (m_st == S_IF || m_st == S_MRD || m_st == S_MWR) begin
      if (!a) begin
        m_wait++;
        if (m_wait == MEM_TIMEOUT) begin
          m_st = S_TRAP; m_tmo = 1; m_wait = 0;
        end
        return;
      end
      m_wait = 0;
    end
    if (m_st == S_IF) begin
      m_st = S_ID;
    end else if (m_st == S_ID) begin
      m_path.delete();
      case (opcode)
        6'b000000:                                   begin m_path.push_back(S_REX); m_path.push_back(S_RWB); end
        6'b100011:                                   begin m_path.push_back(S_MADDR); m_path.push_back(S_MRD); m_path.push_back(S_MWB); end
        6'b101011:                                   begin m_path.push_back(S_MADDR); m_path.push_back(S_MWR); end
        6'b000100, 6'b000101:                        m_path.push_back(S_BR);
        6'b000010:                                   m_path.push_back(S_JMP);
        6'b001000, 6'b001100, 6'b001101, 6'b001111:  begin m_path.push_back(S_IEX); m_path.push_back(S_IWB); end
        default:                                     begin m_path.push_back(S_TRAP); m_ill = 1; end
      endcase
      m_st = m_path.pop_front();
    end else if (m_path.size() > 0) begin
      m_st = m_path.pop_front();
    end else begin
      m_st = S_IF;
      m_ins++;
    end
  endtask

  // Called at a falling edge: drive, record expectation, advance, wait one cycle.
  task automatic cyc(input logic s, input logic a);
    exp_t e;
    stall_in = s;
    mem_ack  = a;
    e.st  = 4'(m_st);
    e.ctl = exp_ctl(m_st, opcode, s, a);
    e.ill = m_ill;
    e.tmo = m_tmo;
    e.cyc = m_cyc;
    e.ins = m_ins;
    e.stl = m_stl;
    exp_q.push_back(e);
    advance(s, a);
    @(negedge multi_clk);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    #3;
    rst_out = 1'b1;
    m_st = S_IF; m_path.delete(); m_wait = 0;
    m_ill = 0; m_tmo = 0; m_cyc = '0; m_ins = '0; m_stl = '0;
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_mem_access", {mem_read, mem_write}, 64'd0);
    check("rst_flags", {illegal_op, mem_timeout}, 64'd0);
    check("rst_counters", {cycle_cnt, instr_cnt, stall_cnt}, 64'd0);
    @(negedge multi_clk);
    @(negedge multi_clk);
    stall_in = 1'b0;
    mem_ack  = 1'b0;
    rst_out  = 1'b0;
  endtask

  // Monitor: compares every queued expectation against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge multi_clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state", 64'(state), 64'(e.st));
        check("controls", 64'(dut_ctl), 64'(e.ctl));
        check("flags", {illegal_op, mem_timeout}, {e.ill, e.tmo});
        check("cycle_cnt", 64'(cycle_cnt), 64'(e.cyc));
        check("instr_cnt", 64'(instr_cnt), 64'(e.ins));
        check("stall_cnt", 64'(stall_cnt), 64'(e.stl));
      end
    end
  end

  initial begin
    logic s, a;
    @(negedge multi_clk);

    // addu: 0 -> 1 -> 6 -> 7 -> 0
    do_reset();
    opcode = 6'b000000;
    repeat (4) cyc(1'b0, 1'b1);
    check("addu_state", 64'(state), 64'd0);
    check("addu_instr_cnt", 64'(instr_cnt), 64'd1);
    check("addu_cycle_cnt", 64'(cycle_cnt), 64'd4);

    // lw with late acks in IF and MRD
    do_reset();
    opcode = 6'b100011;
    cyc(0, 0); cyc(0, 0); cyc(0, 1);
    cyc(0, 0); cyc(0, 0);
    cyc(0, 0); cyc(0, 1);
    cyc(0, 0);
    check("lw_state", 64'(state), 64'd0);
    check("lw_no_timeout", 64'(mem_timeout), 64'd0);

    // bne then j
    do_reset();
    opcode = 6'b000101;
    cyc(0, 1); cyc(0, 0); cyc(0, 0);
    opcode = 6'b000010;
    cyc(0, 1); cyc(0, 0); cyc(0, 0);
    check("br_j_instr_cnt", 64'(instr_cnt), 64'd2);

    // sw stalled three cycles in MWR with ack held high
    do_reset();
    opcode = 6'b101011;
    cyc(0, 1); cyc(0, 0); cyc(0, 0);
    cyc(1, 1); cyc(1, 1); cyc(1, 1);
    cyc(0, 1);
    check("sw_state", 64'(state), 64'd0);
`ifdef MC_STALL_STATS_EN
    check("sw_stall_cnt", 64'(stall_cnt), 64'd3);
`else
    check("sw_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    // fetch never acknowledged -> timeout trap, then reset mid-trap
    do_reset();
    opcode = 6'b000000;
    repeat (MEM_TIMEOUT) cyc(0, 0);
    check("to_state", 64'(state), 64'd12);
    check("to_flag", 64'(mem_timeout), 64'd1);
    cyc(0, 1); cyc(1, 0);
    do_reset();

    // undefined opcode -> trap, everything off, cycles still counted
    opcode = 6'b111111;
    cyc(0, 1); cyc(0, 0);
    cyc(0, 1); cyc(1, 1); cyc(0, 0);
    check("ill_flag", 64'(illegal_op), 64'd1);
    check("ill_controls", 64'(dut_ctl), 64'd0);
    check("ill_cycle_cnt", 64'(cycle_cnt), 64'd5);

    // randomized programs; the last round starves acks to provoke timeouts
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int k = 0; k < 200; k++) begin
        if (m_st == S_TRAP) do_reset();
        if (m_st == S_IF) opcode = ops[$urandom_range(0, 11)];
        s = ($urandom_range(0, 5) == 0);
        a = ($urandom_range(0, (r == 3) ? 7 : 1) == 0);
        cyc(s, a);
      end
    end

    @(negedge multi_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
